// File: rtl/alu_seq.sv
`default_nettype none

`ifndef WIDTH_WORD
`define WIDTH_WORD 8
`endif

// ============================================================================
// Module      : alu_seq
// Description : Registered ALU with a start/busy/done handshake. Ops 000-110
//               complete in one cycle. MUL (111) is an unsigned shift-add
//               multiplier that consumes one multiplier bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
  parameter int WIDTH = `WIDTH_WORD,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_AND = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_NOT = 3'b100;
  localparam logic [2:0] c_OP_MV  = 3'b101;
  localparam logic [2:0] c_OP_SHL = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  // The bit counter runs 0..WIDTH-1; the iteration seen with this value is the last.
  localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [WIDTH-1:0]       r_y;
  logic                   r_carry;
  logic                   r_zero;
  logic                   r_done;
  logic [2*WIDTH-1:0]     r_acc;
  logic [2*WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]       r_mplier;
  logic [SHW-1:0]         r_cnt;

  logic                   w_accept;
  logic                   w_mul_last;
  logic [SHW-1:0]         w_sh;
  logic [WIDTH:0]         w_ext;
  logic [WIDTH-1:0]       w_sop_y;
  logic                   w_sop_c;
  logic [2*WIDTH-1:0]     w_acc_nxt;

  // A request is taken only while no multiply is running; busy requests are dropped.
  assign w_accept   = start && (r_state == S_IDLE);
  assign w_mul_last = (r_state == S_MUL) && (r_cnt == c_CNT_LAST);
  assign w_sh       = b[SHW-1:0];

  // Single-cycle datapath: result and flag for ops 000-110.
  always_comb begin
    w_ext   = '0;
    w_sop_c = 1'b0;
    case (op)
      c_OP_ADD: w_ext = {1'b0, a} + {1'b0, b};
      c_OP_SUB: w_ext = {1'b0, a} - {1'b0, b};
      c_OP_AND: w_ext = {1'b0, a & b};
      c_OP_OR:  w_ext = {1'b0, a | b};
      c_OP_NOT: w_ext = {1'b0, ~a};
      c_OP_MV:  w_ext = {1'b0, a};
      // Shifting the zero-extended operand leaves a[WIDTH-sh] in the top bit.
      c_OP_SHL: w_ext = {1'b0, a} << w_sh;
      default:  w_ext = '0;
    endcase
    w_sop_y = w_ext[WIDTH-1:0];
    // Logic ops report "result non-zero" in carry; arithmetic ops report bit WIDTH.
    if (op == c_OP_AND || op == c_OP_OR || op == c_OP_NOT || op == c_OP_MV) begin
      w_sop_c = |w_sop_y;
    end else begin
      w_sop_c = w_ext[WIDTH];
    end
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Control FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && op == c_OP_MUL) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_last)                 w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers and multiplier datapath; reset discards any in-flight multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y      <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (op == c_OP_MUL) begin
          r_acc    <= '0;
          r_mcand  <= {{WIDTH{1'b0}}, a};
          r_mplier <= b;
          r_cnt    <= '0;
        end else begin
          r_y     <= w_sop_y;
          r_carry <= w_sop_c;
          r_zero  <= ~|w_sop_y;
          r_done  <= 1'b1;
        end
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + SHW'(1);
        if (w_mul_last) begin
          r_y     <= w_acc_nxt[WIDTH-1:0];
          r_carry <= |w_acc_nxt[2*WIDTH-1:WIDTH];
          r_zero  <= ~|w_acc_nxt[WIDTH-1:0];
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign y     = r_y;
  assign carry = r_carry;
  assign zero  = r_zero;
  assign done  = r_done;
  assign busy  = (r_state == S_MUL);

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational datapath ALU.
- Registers every result and adds a start/busy/done handshake, a zero flag, a shift-left op and an iterative multiplier.
- Sits between the register file and the writeback mux. The control FSM issues `start` and stalls on `busy`.

Parameters:
- WIDTH, default `WIDTH_WORD: operand/result width; must be a power of two and at least 2.
- SHW, default $clog2(WIDTH): shift-amount width, derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  3  opcode: ADD=000 SUB=001 AND=010 OR=011 NOT=100 MV=101 SHL=110 MUL=111
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- y  out  WIDTH  registered result
- carry  out  1  registered carry/borrow/overflow flag
- zero  out  1  registered, 1 when y==0
- busy  out  1  MUL in progress
- done  out  1  one-cycle pulse, result valid

Behaviour:
- Reset (async, any state, including mid-MUL):
  - y=0, carry=0, zero=0, busy=0, done=0, state=IDLE.
  - An in-flight MUL is discarded; no done is issued for it.
- States: IDLE, MUL.
- Accept rule: start=1 and busy=0 at a rising edge.
  - op, a and b are captured at that edge.
  - Later input changes do not affect the operation.
  - start while busy=1 is ignored, not queued.
- Single-cycle ops (000–110):
  - Result is written at the accepting edge (latency 1).
  - done=1 for exactly the following cycle; state stays IDLE.
- ADD: {carry,y} = a+b, computed as a (WIDTH+1)-bit sum.
- SUB: {carry,y} = a−b, computed as a (WIDTH+1)-bit difference; carry=1 means borrow (a<b).
- AND / OR / NOT / MV:
  - y = a&b, a|b, ~a, a respectively.
  - carry = |y of the new result; this replaces the undefined old-y behaviour.
- SHL:
  - sh = b[SHW-1:0]; y = a<<sh.
  - carry = a[WIDTH−sh] when sh≠0, else 0.
  - Upper bits of b are ignored.
- MUL (111): unsigned shift-add, one multiplier bit per cycle.
  - Accepting edge E: busy→1, state→MUL, acc=0, multiplicand and multiplier loaded, bit counter=0.
  - Edges E+1 … E+WIDTH: one iteration each.
  - At edge E+WIDTH: y = product[WIDTH-1:0], carry = |product[2·WIDTH-1:WIDTH] (overflow), busy→0, done→1 for one cycle, state→IDLE.
  - Latency is WIDTH cycles; busy is high for exactly WIDTH cycles.
- zero = ~|y, updated on every result write.
- y, carry and zero hold their values between operations; done=0 clears nothing.
- Back-to-back: a start in the cycle where done=1 is accepted, because busy=0 there.
- Invalid input is impossible: all 8 opcodes are defined.

Test Plan:
1. ADD, WIDTH=8, a=0xF0, b=0x20, start for one cycle:
   - one edge later: y=0x10, carry=1, zero=0, done high for 1 cycle, busy never high.
2. SUB, WIDTH=8:
   - a=0x05, b=0x05 → y=0x00, carry=0, zero=1.
   - then a=0x03, b=0x05 → y=0xFE, carry=1, zero=0.
3. MUL, WIDTH=8:
   - a=7, b=6 → busy high for exactly 8 cycles, done on the 8th edge, y=0x2A, carry=0.
   - then a=0x10, b=0x10 → y=0x00, carry=1, zero=1.
4. Ignore while busy:
   - MUL a=3, b=5 accepted; at cycle 3 drive start with op=ADD, a=1, b=1.
   - required: ignored; final y=0x0F and exactly one done pulse.
5. Reset mid-MUL:
   - assert rst asynchronously at cycle 4 of a MUL → y=0, busy=0, done=0 immediately.
   - after release, ADD 1+1 → y=2, done one edge later.
6. SHL, WIDTH=8:
   - a=0x81, b=0x01 → y=0x02, carry=1.
   - b=0x09 → same result (sh=1).
   - b=0x00 → y=0x81, carry=0.
